fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle instruction fetch and phase sequencer for the 8-bit accumulator computer; sits directly upstream of the control unit. It owns the program counter and instruction register, arbitrates the single shared (von Neumann) memory address between instruction fetch and data access, and presents the 3-bit opcode and 5-bit immediate to the control unit. It issues a one-cycle execute strobe that gates the control unit's write enables, so each instruction commits exactly once.

## Interface

- No parameters; data/address width fixed at 8 bits, memory 256 bytes.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  1 = sequencer may start a new instruction; sampled only in FETCH
- mem_rdata  in  8  shared memory read data, valid one cycle after mem_addr
- brnch  in  1  from control unit: current instruction is a branch
- selMemIn  in  1  from control unit: 0 = PC addresses memory, 1 = accumulator
- alu_nz  in  1  ALU "!= 0" result for BNZ: 1 = branch taken
- acc_value  in  8  accumulator contents: data address and branch target
- mem_addr  out  8  shared memory address
- opcode  out  3  IR[7:5] to control unit
- imm  out  5  IR[4:0] to accumulator immediate mux
- exec_en  out  1  commit strobe; downstream regWE/memWE/accWE are ANDed with it
- pc  out  8  current program counter
- state  out  2  sequencer state, for debug/verification

## Operation

- Instruction word: [7:5] opcode, [4:0] immediate. Opcode 111 = LW; all others single-phase execute.
- States (encoding): FETCH=00, DECODE=01, EXEC=10, MEM=11.
- FETCH: mem_addr=pc, exec_en=0. run=1 -> DECODE; run=0 -> stay FETCH, pc unchanged.
- DECODE: mem_addr=pc; IR <= mem_rdata at end of cycle; -> EXEC.
- EXEC: mem_addr = selMemIn ? acc_value : pc.
  - opcode!=111: exec_en=1; pc updated (see below); -> FETCH.
  - opcode==111: exec_en=0; pc unchanged; -> MEM.
- MEM (LW only): mem_addr=acc_value, exec_en=1 (RF captures mem_rdata); pc <= pc+1; -> FETCH.
- PC update in EXEC: brnch=1 and alu_nz=1 -> pc <= acc_value; otherwise pc <= pc+1.
- pc+1 is 8-bit modulo: 0xFF -> 0x00. Branch target taken verbatim, no offset.
- SW: memWE (gated) is high in EXEC with mem_addr=acc_value; the write lands on the EXEC clock edge.
- opcode/imm driven continuously from IR; stable from EXEC through the following DECODE.
- exec_en is decoded combinationally from state/IR; never high outside EXEC/MEM.

## Timing

- Reset (rst_n=0 at a rising edge): pc=0x00, IR=0x00 (opcode=000, imm=0), state=FETCH, exec_en=0, mem_addr=0x00. Takes effect in any state; an in-flight instruction is discarded with no exec_en.
- Memory read latency is exactly 1 cycle; the block has no wait-state input.
- Latency: non-LW instruction = 3 cycles (FETCH, DECODE, EXEC); LW = 4 cycles; pc changes on the final cycle's edge.
- Throughput with run held at 1: one exec_en pulse every 3 cycles (4 for LW), no idle cycles between instructions.
- run deasserted mid-instruction has no effect until the next FETCH; the current instruction completes.
- Branch and wrap are simultaneous-safe: brnch taken with pc=0xFF loads acc_value, not 0x00.
- brnch is ignored outside EXEC.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with run=1, mem_rdata=0x40 -> pc=0x00, state=00, exec_en=0; first DECODE two cycles after release, first exec_en on cycle 3.
- Straight-line: mem[0]=0x41, mem[1]=0x62 (ADD, NAND) -> opcode 010 then 011, imm 0x01 then 0x02; exec_en pulses exactly every 3rd cycle; pc 0->1->2.
- LW: pc=0x05, mem[5]=0xE0, acc_value=0x80, selMemIn=1 -> EXEC mem_addr=0x80 with exec_en=0, MEM mem_addr=0x80 with exec_en=1, pc=0x06 after 4 cycles.
- BNZ: IR=0x80, brnch=1, acc_value=0x10: alu_nz=1 -> pc=0x10; repeat with alu_nz=0 at pc=0x20 -> pc=0x21.
- Wrap: pc=0xFF, mem[0xFF]=0x40 -> after EXEC pc=0x00, next fetch address 0x00.
- Stall and abort: run=0 in FETCH for 5 cycles -> state stays 00, pc constant, exec_en=0; then rst_n=0 during EXEC -> no exec_en that cycle, pc=0x00, state=00.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Bundles the sequencer's memory, control-unit and debug signals.
// The master modport is the sequencer's view; slave is the surrounding datapath.
interface fetch_sequencer_if;
    logic       run;
    logic [7:0] mem_rdata;
    logic       brnch;
    logic       selMemIn;
    logic       alu_nz;
    logic [7:0] acc_value;
    logic [7:0] mem_addr;
    logic [2:0] opcode;
    logic [4:0] imm;
    logic       exec_en;
    logic [7:0] pc;
    logic [1:0] state;

    modport master (
        input  run, mem_rdata, brnch, selMemIn, alu_nz, acc_value,
        output mem_addr, opcode, imm, exec_en, pc, state
    );

    modport slave (
        output run, mem_rdata, brnch, selMemIn, alu_nz, acc_value,
        input  mem_addr, opcode, imm, exec_en, pc, state
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/phase sequencer for the 8-bit accumulator machine.
// Owns PC and IR, steers the single shared memory address between
// instruction fetch and data access, and emits the one-cycle commit strobe.
module fetch_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    localparam logic [1:0] FETCH  = 2'b00;
    localparam logic [1:0] DECODE = 2'b01;
    localparam logic [1:0] EXEC   = 2'b10;
    localparam logic [1:0] MEM    = 2'b11;

    localparam logic [2:0] OP_LW  = 3'b111;

    logic [1:0] state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] pc_inc;
    logic [7:0] addr;
    logic       exec_raw;
    logic       is_lw;
    logic       branch_taken;

    // Sequential increment wraps naturally at 8 bits (0xFF -> 0x00).
    assign pc_inc       = pc_q + 8'd1;
    assign is_lw        = (ir_q[7:5] == OP_LW);
    assign branch_taken = bus.brnch & bus.alu_nz;

    // Next-state, next-PC, IR capture, address steering and strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr     = pc_q;
        exec_raw = 1'b0;

        case (state_q)
            FETCH: begin
                if (bus.run) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Read data for the FETCH-cycle address is valid now.
                ir_d    = bus.mem_rdata;
                state_d = EXEC;
            end
            EXEC: begin
                addr = bus.selMemIn ? bus.acc_value : pc_q;
                if (is_lw) begin
                    // Load needs a second cycle for its data read.
                    state_d = MEM;
                end else begin
                    exec_raw = 1'b1;
                    // Taken branch wins over the wrap: target used verbatim.
                    pc_d     = branch_taken ? bus.acc_value : pc_inc;
                    state_d  = FETCH;
                end
            end
            MEM: begin
                addr     = bus.acc_value;
                exec_raw = 1'b1;
                pc_d     = pc_inc;
                state_d  = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, PC and IR registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all three
        // registers update together from the values seen before the edge.
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // An instruction caught by reset in EXEC/MEM must not commit, so the
    // strobe is killed combinationally while reset is asserted.
    assign bus.exec_en  = exec_raw & rst_n;
    assign bus.mem_addr = addr;
    assign bus.opcode   = ir_q[7:5];
    assign bus.imm      = ir_q[4:0];
    assign bus.pc       = pc_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a 256-byte memory model with
// one-cycle read latency, a commit scoreboard and per-scenario tasks.
module tb_fetch_sequencer;
    localparam logic [1:0] S_FETCH  = 2'b00;
    localparam logic [1:0] S_DECODE = 2'b01;
    localparam logic [1:0] S_EXEC   = 2'b10;
    localparam logic [1:0] S_MEM    = 2'b11;

    typedef struct {
        logic [2:0] op;
        logic [4:0] imm;
        logic [7:0] addr;
    } commit_t;

    logic clk;
    logic rst_n;
    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    commit_t    sb [$];
    int         tests;
    int         fails;
    int         exec_count;
    int         cyc;
    int         last_exec_cyc;
    logic [7:0] m_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared memory: data for an address is returned one cycle later.
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    // Commit monitor: every exec_en pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.exec_en === 1'b1) begin
            commit_t e;
            exec_count++;
            last_exec_cyc = cyc;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_exec: exec_en=1 at pc=%02h with no instruction pending", bus.pc);
            end else begin
                e = sb.pop_front();
                if (bus.opcode !== e.op || bus.imm !== e.imm || bus.mem_addr !== e.addr) begin
                    fails++;
                    $display("FAIL commit: got op=%03b imm=%02h addr=%02h, expected op=%03b imm=%02h addr=%02h",
                             bus.opcode, bus.imm, bus.mem_addr, e.op, e.imm, e.addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Run one instruction from a FETCH negedge until the next FETCH.
    task automatic do_instr(input logic [7:0] word, input logic br, input logic nz,
                            input logic sel, input logic [7:0] acc, input bit drop_run);
        commit_t    e;
        logic       lw;
        logic [7:0] exp_pc;
        logic [7:0] exec_addr;
        int         exp_n;
        int         n;
        int         start_exec;
        lw        = (word[7:5] == 3'b111);
        exec_addr = sel ? acc : m_pc;
        exp_pc    = lw ? 8'(m_pc + 8'd1) : ((br && nz) ? acc : 8'(m_pc + 8'd1));
        exp_n     = lw ? 4 : 3;
        tests++;
        if (bus.state !== S_FETCH) begin
            fails++;
            $display("FAIL start_state: got %02b, expected %02b", bus.state, S_FETCH);
        end
        mem[m_pc]    = word;
        bus.brnch    = br;
        bus.alu_nz   = nz;
        bus.selMemIn = sel;
        bus.acc_value = acc;
        bus.run      = 1'b1;
        e.op   = word[7:5];
        e.imm  = word[4:0];
        e.addr = lw ? acc : exec_addr;
        sb.push_back(e);
        start_exec = exec_count;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop_run && n == 1) bus.run = 1'b0;
            if (n == 1) begin
                tests++;
                if (bus.state !== S_DECODE || bus.exec_en !== 1'b0) begin
                    fails++;
                    $display("FAIL decode_phase: got state=%02b exec_en=%b, expected 01/0", bus.state, bus.exec_en);
                end
            end
            if (n == 2) begin
                tests++;
                if (bus.state !== S_EXEC || bus.mem_addr !== exec_addr || bus.exec_en !== !lw) begin
                    fails++;
                    $display("FAIL exec_phase: got state=%02b addr=%02h exec_en=%b, expected 10/%02h/%b",
                             bus.state, bus.mem_addr, bus.exec_en, exec_addr, !lw);
                end
            end
            if (n == 3 && lw) begin
                tests++;
                if (bus.state !== S_MEM || bus.mem_addr !== acc || bus.exec_en !== 1'b1) begin
                    fails++;
                    $display("FAIL mem_phase: got state=%02b addr=%02h exec_en=%b, expected 11/%02h/1",
                             bus.state, bus.mem_addr, bus.exec_en, acc);
                end
            end
        end while (bus.state !== S_FETCH && n < 10);
        tests++;
        if (n != exp_n) begin
            fails++;
            $display("FAIL latency: got %0d cycles, expected %0d", n, exp_n);
        end
        tests++;
        if (exec_count - start_exec != 1) begin
            fails++;
            $display("FAIL exec_pulses: got %0d, expected 1", exec_count - start_exec);
        end
        tests++;
        if (bus.pc !== exp_pc) begin
            fails++;
            $display("FAIL pc_update: got %02h, expected %02h", bus.pc, exp_pc);
        end
        m_pc         = exp_pc;
        bus.brnch    = 1'b0;
        bus.alu_nz   = 1'b0;
        bus.selMemIn = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.pc !== 8'h00 || bus.state !== S_FETCH || bus.exec_en !== 1'b0 ||
            bus.mem_addr !== 8'h00 || bus.opcode !== 3'b000 || bus.imm !== 5'h00) begin
            fails++;
            $display("FAIL reset_state: got pc=%02h st=%02b ex=%b addr=%02h op=%03b imm=%02h, expected 00/00/0/00/000/00",
                     bus.pc, bus.state, bus.exec_en, bus.mem_addr, bus.opcode, bus.imm);
        end
        rst_n = 1'b1;
        m_pc  = 8'h00;
    endtask

    task automatic test_straight();
        int c1;
        do_instr(8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        c1 = last_exec_cyc;
        do_instr(8'h62, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tests++;
        if (last_exec_cyc - c1 != 3) begin
            fails++;
            $display("FAIL throughput3: got gap %0d, expected 3", last_exec_cyc - c1);
        end
    endtask

    task automatic test_sw();
        do_instr(8'hA3, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
    endtask

    task automatic test_lw();
        int c1;
        do_instr(8'h80, 1'b1, 1'b1, 1'b0, 8'h05, 1'b0);
        do_instr(8'hE0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
        c1 = last_exec_cyc;
        do_instr(8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tests++;
        if (last_exec_cyc - c1 != 3) begin
            fails++;
            $display("FAIL lw_followup_gap: got %0d, expected 3", last_exec_cyc - c1);
        end
    endtask

    task automatic test_bnz();
        do_instr(8'h80, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0);
        do_instr(8'h80, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0);
        do_instr(8'h80, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
        // brnch without an active branch opcode path still follows alu_nz=0
        do_instr(8'h41, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0);
    endtask

    task automatic test_wrap();
        do_instr(8'h80, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        do_instr(8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tests++;
        if (bus.mem_addr !== 8'h00) begin
            fails++;
            $display("FAIL wrap_fetch_addr: got %02h, expected 00", bus.mem_addr);
        end
        do_instr(8'h80, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        do_instr(8'h80, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    endtask

    task automatic test_stall_abort();
        do_instr(8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.state !== S_FETCH || bus.pc !== m_pc || bus.exec_en !== 1'b0) begin
                fails++;
                $display("FAIL stall: got st=%02b pc=%02h ex=%b, expected 00/%02h/0", bus.state, bus.pc, bus.exec_en, m_pc);
            end
        end
        mem[m_pc] = 8'h41;
        bus.run = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.state !== S_EXEC || bus.exec_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_exec: got st=%02b ex=%b, expected 10/0", bus.state, bus.exec_en);
        end
        @(negedge clk);
        tests++;
        if (bus.pc !== 8'h00 || bus.state !== S_FETCH || bus.exec_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: got pc=%02h st=%02b ex=%b, expected 00/00/0", bus.pc, bus.state, bus.exec_en);
        end
        rst_n = 1'b1;
        m_pc  = 8'h00;
        do_instr(8'h62, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exec_count = 0;
        cyc = 0;
        last_exec_cyc = 0;
        m_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h40;
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.brnch = 1'b0;
        bus.selMemIn = 1'b0;
        bus.alu_nz = 1'b0;
        bus.acc_value = 8'h00;
        test_reset();
        test_straight();
        test_sw();
        test_lw();
        test_bnz();
        test_wrap();
        test_stall_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
